// File: rtl/wb2axil_bridge.sv
// -----------------------------------------------------------------------------
// wb2axil_bridge
//   Wishbone-pipelined slave to AXI4-Lite master bridge. One outstanding
//   transaction, single clock domain. A Wishbone request is registered in IDLE,
//   issued on AW/W (independent handshakes) or AR, the AXI response is waited
//   for, and a one-cycle ack (OKAY/EXOKAY) or err (SLVERR/DECERR) pulse is
//   returned. If wb_cyc_i drops while busy the AXI side still completes but no
//   completion pulse is given.
//
//   Optional feature macro: WB2AXIL_TIMEOUT_EN
//     When defined, a response that has not arrived within TIMEOUT_CYCLES
//     cycles of issuing the request produces one err pulse; the bridge then
//     drains the late AXI handshakes (DRAIN state) before returning to IDLE.
//
// Ports
//   m_axi_aclk, m_axi_aresetn : clock, synchronous active-low reset
//   wb_cyc_i/stb_i/we_i       : Wishbone cycle, strobe, write-enable
//   wb_addr_i/data_i/sel_i    : Wishbone address, write data, byte selects
//   wb_stall_o/ack_o/err_o    : Wishbone stall, success and error pulses
//   wb_data_o                 : read data, valid with ack, held until next read
//   m_axi_aw*, m_axi_w*       : AXI write address / write data channels
//   m_axi_b*                  : AXI write response channel
//   m_axi_ar*, m_axi_r*       : AXI read address / read data channels
// -----------------------------------------------------------------------------
module wb2axil_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_addr_i,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic                    wb_stall_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp
);

  localparam int STRB_W = DATA_WIDTH / 8;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("wb2axil_bridge: DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb2axil_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, DRAIN
  } state_t;

  state_t state;
  logic   cyc_lost;   // wb_cyc_i was seen low at some point while busy

  // SLVERR (10) and DECERR (11) are errors; OKAY (00) and EXOKAY (01) are not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

  logic aw_fire, w_fire, ar_fire;
  logic aw_left, w_left;   // channel still pending after the current edge
  logic keep;              // completion pulse allowed for this transaction

  assign aw_fire = m_axi_awvalid && m_axi_awready;
  assign w_fire  = m_axi_wvalid  && m_axi_wready;
  assign ar_fire = m_axi_arvalid && m_axi_arready;
  assign aw_left = m_axi_awvalid && !m_axi_awready;
  assign w_left  = m_axi_wvalid  && !m_axi_wready;
  assign keep    = wb_cyc_i && !cyc_lost;

`ifdef WB2AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             is_wr;
  logic             completing;

  assign completing = (state == WR_RESP && m_axi_bvalid) ||
                      (state == RD_RESP && m_axi_rvalid);
`endif

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state         <= IDLE;
      cyc_lost      <= 1'b0;
      wb_stall_o    <= 1'b0;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
      wb_data_o     <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
`ifdef WB2AXIL_TIMEOUT_EN
      to_cnt        <= '0;
      is_wr         <= 1'b0;
`endif
    end else begin
      if (state != IDLE && !wb_cyc_i) cyc_lost <= 1'b1;

      case (state)
        IDLE: begin
          wb_stall_o <= 1'b0;
          if (wb_cyc_i && wb_stb_i) begin
            wb_stall_o <= 1'b1;
            cyc_lost   <= 1'b0;
`ifdef WB2AXIL_TIMEOUT_EN
            to_cnt     <= '0;
            is_wr      <= wb_we_i;
`endif
            if (wb_we_i) begin
              m_axi_awaddr  <= wb_addr_i;
              m_axi_wdata   <= wb_data_i;
              m_axi_wstrb   <= STRB_W'(wb_sel_i);
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              m_axi_araddr  <= wb_addr_i;
              m_axi_arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          if (aw_fire) m_axi_awvalid <= 1'b0;
          if (w_fire)  m_axi_wvalid  <= 1'b0;
          if (!aw_left && !w_left) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            wb_ack_o     <= keep && !resp_is_err(m_axi_bresp);
            wb_err_o     <= keep &&  resp_is_err(m_axi_bresp);
            state        <= DONE;
          end
        end

        RD_REQ: begin
          if (ar_fire) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            wb_data_o    <= m_axi_rdata;
            wb_ack_o     <= keep && !resp_is_err(m_axi_rresp);
            wb_err_o     <= keep &&  resp_is_err(m_axi_rresp);
            state        <= DONE;
          end
        end

        DONE: begin
          wb_ack_o   <= 1'b0;
          wb_err_o   <= 1'b0;
          wb_stall_o <= 1'b0;
          state      <= IDLE;
        end

`ifdef WB2AXIL_TIMEOUT_EN
        DRAIN: begin
          // Late handshakes are still honoured so the fabric is left clean;
          // the response itself is thrown away.
          wb_err_o <= 1'b0;
          if (aw_fire) m_axi_awvalid <= 1'b0;
          if (w_fire)  m_axi_wvalid  <= 1'b0;
          if (ar_fire) m_axi_arvalid <= 1'b0;
          if ((is_wr && m_axi_bvalid) || (!is_wr && m_axi_rvalid)) begin
            m_axi_bready <= 1'b0;
            m_axi_rready <= 1'b0;
            wb_stall_o   <= 1'b0;
            state        <= IDLE;
          end
        end
`endif

        default: state <= IDLE;
      endcase

`ifdef WB2AXIL_TIMEOUT_EN
      // Overrides the normal next-state when the response window expires.
      if (state == WR_REQ || state == WR_RESP ||
          state == RD_REQ || state == RD_RESP) begin
        to_cnt <= to_cnt + 1'b1;
        if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1) && !completing) begin
          wb_ack_o     <= 1'b0;
          wb_err_o     <= keep;
          m_axi_bready <= is_wr;
          m_axi_rready <= !is_wr;
          state        <= DRAIN;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_wb2axil_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb2axil_bridge
//   Directed bench for wb2axil_bridge (32-bit data). Inputs are driven on the
//   falling edge, outputs checked on the falling edge, one linear sequence.
// -----------------------------------------------------------------------------
module tb_wb2axil_bridge;

`ifdef WB2AXIL_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 256;
`endif

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cyc, stb, we;
  logic [31:0] addr, wdat;
  logic [3:0]  sel;
  logic        stall, ack, err;
  logic [31:0] rdat_o;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wb2axil_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(aresetn),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_data_i(wdat), .wb_sel_i(sel),
    .wb_stall_o(stall), .wb_ack_o(ack), .wb_err_o(err), .wb_data_o(rdat_o),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_bus();
    cyc = 0; stb = 0; we = 0; addr = '0; wdat = '0; sel = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
  endtask

  // Presents a request for edge T and returns in cycle T+1 with cyc held.
  task automatic req(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    cyc = 1; stb = 1; we = w; addr = a; wdat = d; sel = s;
    step();
    stb = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int pulses;
    idle_bus();
    aresetn = 0;
    step(); step();
    chk("rst_stall",   stall,   0);
    chk("rst_ack",     ack,     0);
    chk("rst_err",     err,     0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready",  bready,  0);
    chk("rst_awaddr",  awaddr,  0);
    chk("rst_rdata_o", rdat_o,  0);
    aresetn = 1;
    step();

    // Write, zero-wait slave
    awready = 1; wready = 1;
    req(1, 32'hAA, 32'hDEADBEEF, 4'hF);
    chk("w1_awvalid", awvalid, 1);
    chk("w1_wvalid",  wvalid,  1);
    chk("w1_awaddr",  awaddr,  32'hAA);
    chk("w1_wdata",   wdata,   32'hDEADBEEF);
    chk("w1_wstrb",   wstrb,   4'hF);
    chk("w1_stall",   stall,   1);
    step();                                   // T+2
    chk("w1_valids_low", {awvalid, wvalid}, 2'b00);
    chk("w1_bready", bready, 1);
    chk("w1_ack_early", ack, 0);
    bvalid = 1; bresp = 2'b00;
    step();                                   // T+3
    bvalid = 0;
    chk("w1_ack", ack, 1);
    chk("w1_err", err, 0);
    step();                                   // T+4
    chk("w1_ack_pulse", ack, 0);
    chk("w1_stall_idle", stall, 0);
    idle_bus(); step();

    // Write, awready delayed three cycles
    awready = 0; wready = 1;
    req(1, 32'h100, 32'h0BADF00D, 4'h3);
    chk("w2_both_valid", {awvalid, wvalid}, 2'b11);
    step();                                   // T+2
    chk("w2_wvalid_drop", wvalid, 0);
    chk("w2_awvalid_t2", awvalid, 1);
    step();                                   // T+3
    chk("w2_awvalid_t3", awvalid, 1);
    chk("w2_awaddr_t3", awaddr, 32'h100);
    step();                                   // T+4
    chk("w2_awvalid_t4", awvalid, 1);
    chk("w2_wstrb", wstrb, 4'h3);
    awready = 1;
    step();                                   // T+5
    chk("w2_awvalid_drop", awvalid, 0);
    chk("w2_bready", bready, 1);
    chk("w2_ack_early", ack, 0);
    bvalid = 1;
    step();                                   // T+6
    bvalid = 0;
    chk("w2_ack", ack, 1);
    step();
    chk("w2_ack_pulse", ack, 0);
    idle_bus(); step();

    // Read, zero-wait, OKAY
    arready = 1;
    req(0, 32'h40, 32'h0, 4'h0);
    chk("r1_arvalid", arvalid, 1);
    chk("r1_araddr",  araddr,  32'h40);
    chk("r1_awvalid", awvalid, 0);
    step();                                   // T+2
    chk("r1_rready", rready, 1);
    chk("r1_arvalid_drop", arvalid, 0);
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
    step();                                   // T+3
    rvalid = 0; rdata = 32'hFFFFFFFF;
    chk("r1_ack", ack, 1);
    chk("r1_err", err, 0);
    chk("r1_data", rdat_o, 32'h12345678);
    step();
    chk("r1_ack_pulse", ack, 0);
    chk("r1_data_hold", rdat_o, 32'h12345678);
    idle_bus(); step();

    // Read, SLVERR
    arready = 1;
    req(0, 32'h44, 32'h0, 4'h0);
    step();
    rvalid = 1; rdata = 32'h0; rresp = 2'b10;
    step();                                   // T+3
    rvalid = 0;
    chk("r2_err", err, 1);
    chk("r2_ack", ack, 0);
    step();
    chk("r2_err_pulse", err, 0);
    chk("r2_ack_after", ack, 0);
    idle_bus(); step();

    // Read, EXOKAY counts as success
    arready = 1;
    req(0, 32'h48, 32'h0, 4'h0);
    step();
    rvalid = 1; rdata = 32'hCAFE0001; rresp = 2'b01;
    step();
    rvalid = 0;
    chk("r3_exokay_ack", {ack, err}, 2'b10);
    chk("r3_data", rdat_o, 32'hCAFE0001);
    idle_bus(); step(); step();

    // Write with DECERR
    awready = 1; wready = 1;
    req(1, 32'h8, 32'h1, 4'h1);
    step();
    bvalid = 1; bresp = 2'b11;
    step();
    bvalid = 0;
    chk("w3_decerr", {ack, err}, 2'b01);
    idle_bus(); step(); step();

    // Write with sel = 0 still issues a transfer
    awready = 1; wready = 1;
    req(1, 32'hC, 32'h55AA55AA, 4'h0);
    chk("w4_awvalid", awvalid, 1);
    chk("w4_wstrb_zero", wstrb, 4'h0);
    step();
    bvalid = 1; bresp = 2'b00;
    step();
    bvalid = 0;
    chk("w4_ack", ack, 1);
    idle_bus(); step(); step();

    // Write with cyc dropped at T+1
    awready = 1; wready = 1;
    req(1, 32'h20, 32'h77, 4'hF);
    cyc = 0;
    step();                                   // T+2
    chk("w5_bready", bready, 1);
    bvalid = 1;
    step();                                   // T+3 (DONE)
    bvalid = 0;
    chk("w5_no_cpl", {ack, err}, 2'b00);
    chk("w5_stall_done", stall, 1);
    step();                                   // T+4
    chk("w5_no_cpl_after", {ack, err}, 2'b00);
    chk("w5_stall_idle", stall, 0);
    idle_bus(); step();

    // Reset in the middle of a write abandons it
    awready = 0; wready = 0;
    req(1, 32'h30, 32'h99, 4'hF);
    chk("w6_awvalid", awvalid, 1);
    aresetn = 0;
    step();
    chk("w6_rst_awvalid", awvalid, 0);
    chk("w6_rst_stall", stall, 0);
    chk("w6_rst_awaddr", awaddr, 0);
    aresetn = 1; cyc = 0; bvalid = 1;
    step();
    bvalid = 0;
    chk("w6_rst_no_cpl", {ack, err}, 2'b00);
    chk("w6_rst_bready", bready, 0);
    idle_bus(); step();

`ifdef WB2AXIL_TIMEOUT_EN
    // Read whose response never arrives in the window
    arready = 1;
    req(0, 32'h50, 32'h0, 4'h0);
    step();
    chk("to_rready", rready, 1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (err) pulses++;
    end
    chk("to_err_once", pulses, 1);
    chk("to_no_ack", ack, 0);
    chk("to_stall_drain", stall, 1);
    chk("to_rready_drain", rready, 1);
    rvalid = 1; rdata = 32'hDEAD0000;
    step();
    rvalid = 0;
    chk("to_stall_idle", stall, 0);
    chk("to_drain_no_cpl", {ack, err}, 2'b00);
    idle_bus(); step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
